alu_seq_core: RTL and testbench
===============================

// Module: alu_seq_core
// PURPOSE
//  Registered, WIDTH-parametrised successor to the 8-bit combinational ALU: same 16-opcode map,
//  adds signed/unsigned mode, multi-cycle iterative MUL/DIV, and valid/ready handshakes on both sides.
//  Sits between the operand/decode stage and the writeback stage; one operation in flight at a time.
// PARAMETERS
//  WIDTH     8  operand/result width in bits; legal range 4..32.
//  FAST_MUL  0  0: MUL is shift-add over WIDTH cycles; 1: MUL completes in 1 cycle.
// PORTS
//  clk            in   1      single clock, all state updates on rising edge.
//  rst            in   1      synchronous reset, active-high.
//  in_valid       in   1      op_a/op_b/opcode/signed_mode are valid.
//  in_ready       out  1      block can accept an operation (high only in IDLE).
//  op_a, op_b     in   WIDTH  operands.
//  opcode         in   4      operation select (map below).
//  signed_mode    in   1      1: two's-complement semantics for SHR, GT, MUL/DIV overflow and DIV.
//  out_valid      out  1      result and flags are valid; held until out_ready.
//  out_ready      in   1      downstream accepts the result.
//  result         out  WIDTH  registered result.
//  carry_flag, zero_flag, overflow_flag, negative_flag, div0_flag   out 1 each; registered flags.
// BEHAVIOUR
//  Reset: state=IDLE; result=0; all flags=0; out_valid=0; in_ready=0 while rst=1, 1 the cycle after.
//  Reset mid-operation aborts it; no out_valid is produced for the aborted operation.
//  FSM: IDLE --(in_valid&in_ready)--> EXEC (single-cycle ops) or BUSY (iterative MUL/DIV).
//       EXEC --> DONE after 1 cycle. BUSY: counter from WIDTH-1 down to 0 --> DONE.
//       DONE --(out_valid&out_ready)--> IDLE. in_ready=(state==IDLE); out_valid=(state==DONE).
//  Latency (accept edge to out_valid rising): 2 cycles for single-cycle ops; WIDTH+1 for iterative ops.
//  result/flags stay stable while out_valid=1 and out_ready=0; inputs are ignored outside IDLE.
//  Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SHL, 5 SHR, 6 ROL, 7 ROR, 8 AND, 9 OR, A XOR, B NOR,
//           C NAND, D XNOR, E GT (1/0), F EQ (1/0). All values modulo 2^WIDTH.
//  ADD: C = carry out of bit WIDTH-1; V = same-sign operands with result sign different.
//  SUB: C = borrow (a<b unsigned); V = operand signs differ and result sign differs from a.
//  MUL: result = low WIDTH bits of the 2*WIDTH product; V=1 if the high half is non-zero (unsigned)
//       or not the sign extension of result (signed). Signed MUL works on magnitudes, negates at end.
//  DIV: restoring, one quotient bit per cycle, truncation toward zero in signed mode.
//       b==0: result=0, div0_flag=1, 1-cycle path (EXEC). Signed a=MIN, b=-1: result=MAX (2^(W-1)-1),
//       V=1, 1-cycle path. Remainder discarded.
//  SHL/ROL/ROR by 1; SHR by 1, logical if signed_mode=0, arithmetic if 1. C = bit shifted out; V=0.
//  GT compares signed if signed_mode=1 else unsigned. Logic ops/compares: C=0, V=0.
//  Every op: N = result[WIDTH-1]; Z = (result==0). div0_flag=0 except DIV by zero.
//  Flags and result captured together on the cycle entering DONE; never change mid-DONE.
// STRUCTURE
//  alu_pkg: opcode localparams (ALU_OP_ADD..ALU_OP_EQ), FSM state encodings, flag bit indices.
//  Sub-module alu_muldiv_iter: iterative shift-add multiplier / restoring divider with
//  start/busy/done, magnitude conversion and sign fix-up; top holds FSM, handshakes, simple ops.
// TESTING  (WIDTH=8, FAST_MUL=0 unless noted)
//  ADD a=8'h7F b=8'h01 -> result 8'h80, V=1 N=1 C=0 Z=0, out_valid 2 cycles after accept.
//  SUB a=8'h00 b=8'h01 -> 8'hFF, C=1 N=1; then EQ a=b=8'h5A -> 8'h01, Z=0.
//  MUL signed a=-3 (8'hFD) b=7 -> 8'hEB (-21), V=0, out_valid at accept+9; unsigned 8'h20*8'h10 -> 8'h00, V=1 Z=1.
//  DIV signed a=-7 b=2 -> 8'hFD (-3); DIV a=8'h80 b=8'hFF signed -> 8'h7F V=1 in 2 cycles; b=0 -> 0, div0=1 Z=1.
//  Backpressure: out_ready=0 for 5 cycles -> result/flags stable, in_ready=0, new in_valid ignored.
//  rst asserted mid-DIV (cycle 4 of BUSY) -> next cycle outputs all 0, out_valid never rises; next op correct.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the sequential ALU core:
//   - 4-bit opcode map (ALU_OP_ADD .. ALU_OP_EQ)
//   - FSM state encodings of the top-level controller
//   - bit positions of the packed flag vector held by the core
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam logic [3:0] ALU_OP_ADD  = 4'h0;
   localparam logic [3:0] ALU_OP_SUB  = 4'h1;
   localparam logic [3:0] ALU_OP_MUL  = 4'h2;
   localparam logic [3:0] ALU_OP_DIV  = 4'h3;
   localparam logic [3:0] ALU_OP_SHL  = 4'h4;
   localparam logic [3:0] ALU_OP_SHR  = 4'h5;
   localparam logic [3:0] ALU_OP_ROL  = 4'h6;
   localparam logic [3:0] ALU_OP_ROR  = 4'h7;
   localparam logic [3:0] ALU_OP_AND  = 4'h8;
   localparam logic [3:0] ALU_OP_OR   = 4'h9;
   localparam logic [3:0] ALU_OP_XOR  = 4'hA;
   localparam logic [3:0] ALU_OP_NOR  = 4'hB;
   localparam logic [3:0] ALU_OP_NAND = 4'hC;
   localparam logic [3:0] ALU_OP_XNOR = 4'hD;
   localparam logic [3:0] ALU_OP_GT   = 4'hE;
   localparam logic [3:0] ALU_OP_EQ   = 4'hF;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_BUSY = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Packed flag vector layout
   localparam int FLAG_C = 0;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 2;
   localparam int FLAG_N = 3;
   localparam int FLAG_D = 4;
   localparam int FLAG_W = 5;

endpackage

// File: rtl/alu_muldiv_iter.sv
// ---------------------------------------------------------------------------
// alu_muldiv_iter
// Iterative MSB-first shift-add multiplier / restoring divider. One product
// or quotient bit per cycle, WIDTH cycles per operation. Signed operands are
// converted to magnitudes on start and the sign is re-applied on the way out.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset (aborts work)
//   i_start             load operands and begin (only while not busy)
//   i_is_div            1: divide, 0: multiply
//   i_signed            two's-complement operands
//   i_a, i_b            operands (dividend/divisor for divide)
//   o_busy              operation in progress
//   o_done              final step is being taken this cycle
//   o_result            low WIDTH bits of product, or quotient (valid with o_done)
//   o_overflow          product does not fit WIDTH bits (valid with o_done)
// ---------------------------------------------------------------------------
module alu_muldiv_iter #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_is_div,
   input  logic             i_signed,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result,
   output logic             o_overflow
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0]   W_ZERO   = {WIDTH{1'b0}};
   localparam logic [2*WIDTH-1:0] D_ZERO   = {(2*WIDTH){1'b0}};

   logic                 r_busy;
   logic [CW-1:0]        r_cnt;
   logic                 r_is_div;
   logic                 r_signed;
   logic                 r_neg;
   logic [WIDTH-1:0]     r_ma;
   logic [WIDTH-1:0]     r_mb;
   logic [2*WIDTH-1:0]   r_acc;   // product, or quotient in the low half
   logic [WIDTH-1:0]     r_rem;

   logic                 w_a_neg;
   logic                 w_b_neg;
   logic [WIDTH-1:0]     w_a_mag;
   logic [WIDTH-1:0]     w_b_mag;
   logic [2*WIDTH-1:0]   w_mul_next;
   logic [WIDTH:0]       w_rem_shift;
   logic [WIDTH:0]       w_rem_diff;
   logic                 w_ge;
   logic [WIDTH-1:0]     w_rem_next;
   logic [WIDTH-1:0]     w_qbit;
   logic [WIDTH-1:0]     w_quo_next;
   logic [2*WIDTH-1:0]   w_mag;
   logic [2*WIDTH-1:0]   w_fix;

   // Operand magnitudes taken at start
   always_comb begin
      w_a_neg = i_signed & i_a[WIDTH-1];
      w_b_neg = i_signed & i_b[WIDTH-1];
      w_a_mag = w_a_neg ? (W_ZERO - i_a) : i_a;
      w_b_mag = w_b_neg ? (W_ZERO - i_b) : i_b;
   end

   // One iteration step for both datapaths, indexed by the bit counter
   always_comb begin
      w_mul_next  = {r_acc[2*WIDTH-2:0], 1'b0}
                  + (r_mb[r_cnt] ? {W_ZERO, r_ma} : D_ZERO);
      w_rem_shift = {r_rem, r_ma[r_cnt]};
      w_rem_diff  = w_rem_shift - {1'b0, r_mb};
      // The shifted remainder is always below 2*divisor, so the top bit of
      // the difference is set exactly when the trial subtraction underflows.
      w_ge        = ~w_rem_diff[WIDTH];
      w_rem_next  = w_ge ? w_rem_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
      w_qbit      = {{(WIDTH-1){1'b0}}, w_ge} << r_cnt;
      w_quo_next  = r_acc[WIDTH-1:0] | w_qbit;
   end

   // Final value with sign fix-up; meaningful on the last step
   always_comb begin
      w_mag = r_is_div ? {W_ZERO, w_quo_next} : w_mul_next;
      w_fix = r_neg ? (D_ZERO - w_mag) : w_mag;
      if (r_is_div) begin
         o_overflow = 1'b0;
      end else if (r_signed) begin
         o_overflow = (w_fix[2*WIDTH-1:WIDTH] != {WIDTH{w_fix[WIDTH-1]}});
      end else begin
         o_overflow = (w_fix[2*WIDTH-1:WIDTH] != W_ZERO);
      end
      o_result = w_fix[WIDTH-1:0];
      o_done   = r_busy & (r_cnt == CNT_ZERO);
      o_busy   = r_busy;
   end

   // Operand load and per-cycle iteration
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_busy   <= 1'b0;
         r_cnt    <= CNT_ZERO;
         r_is_div <= 1'b0;
         r_signed <= 1'b0;
         r_neg    <= 1'b0;
         r_ma     <= W_ZERO;
         r_mb     <= W_ZERO;
         r_acc    <= D_ZERO;
         r_rem    <= W_ZERO;
      end else if (i_start) begin
         r_busy   <= 1'b1;
         r_cnt    <= CNT_LAST;
         r_is_div <= i_is_div;
         r_signed <= i_signed;
         r_neg    <= w_a_neg ^ w_b_neg;
         r_ma     <= w_a_mag;
         r_mb     <= w_b_mag;
         r_acc    <= D_ZERO;
         r_rem    <= W_ZERO;
      end else if (r_busy) begin
         if (r_is_div) begin
            r_rem <= w_rem_next;
            r_acc <= {r_acc[2*WIDTH-1:WIDTH], w_quo_next};
         end else begin
            r_acc <= w_mul_next;
         end
         r_cnt <= r_cnt - CNT_ONE;
         if (r_cnt == CNT_ZERO) begin
            r_busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq_core.sv
// ---------------------------------------------------------------------------
// alu_seq_core
// Registered, WIDTH-parametrised ALU with valid/ready handshakes on both
// sides and one operation in flight. Single-cycle ops pass through EXEC;
// MUL (unless FAST_MUL) and non-special DIV iterate in alu_muldiv_iter.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       operation handshake (ready only in IDLE)
//   op_a, op_b, opcode        operands and operation select
//   signed_mode               two's-complement semantics where relevant
//   out_valid / out_ready     result handshake (valid held until ready)
//   result                    registered result
//   carry/zero/overflow/negative/div0_flag   registered flags
// ---------------------------------------------------------------------------
module alu_seq_core #(
   parameter int WIDTH    = 8,
   parameter int FAST_MUL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [3:0]       opcode,
   input  logic             signed_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_flag,
   output logic             zero_flag,
   output logic             overflow_flag,
   output logic             negative_flag,
   output logic             div0_flag
);

   import alu_pkg::*;

   localparam logic [WIDTH-1:0] W_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] W_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] W_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] W_MAX  = {1'b0, {(WIDTH-1){1'b1}}};

   logic [1:0]          r_state;
   logic [WIDTH-1:0]    r_a;
   logic [WIDTH-1:0]    r_b;
   logic [3:0]          r_op;
   logic                r_sgn;
   logic [WIDTH-1:0]    r_result;
   logic [FLAG_W-1:0]   r_flags;

   logic                w_accept;
   logic                w_div_special;
   logic                w_iter;
   logic                w_md_busy;
   logic                w_md_done;
   logic [WIDTH-1:0]    w_md_result;
   logic                w_md_overflow;

   logic [WIDTH-1:0]    w_res;
   logic                w_c;
   logic                w_v;
   logic                w_d;
   logic [WIDTH:0]      w_wide;
   logic [2*WIDTH-1:0]  w_pa;
   logic [2*WIDTH-1:0]  w_pb;
   logic [2*WIDTH-1:0]  w_prod;
   logic [FLAG_W-1:0]   w_flags_exec;
   logic [FLAG_W-1:0]   w_flags_md;

   // Handshake and routing decisions
   always_comb begin
      in_ready = (r_state == ST_IDLE) & ~w_md_busy & ~rst;
      w_accept = in_valid & in_ready;
      // DIV by zero and MIN / -1 have fixed answers and take the fast path
      w_div_special = (opcode == ALU_OP_DIV) &&
                      ((op_b == W_ZERO) || (signed_mode && (op_a == W_MIN) && (op_b == W_ONES)));
      w_iter = ((opcode == ALU_OP_MUL) && (FAST_MUL == 0)) ||
               ((opcode == ALU_OP_DIV) && !w_div_special);
   end

   alu_muldiv_iter #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_start    (w_accept & w_iter),
      .i_is_div   (opcode == ALU_OP_DIV),
      .i_signed   (signed_mode),
      .i_a        (op_a),
      .i_b        (op_b),
      .o_busy     (w_md_busy),
      .o_done     (w_md_done),
      .o_result   (w_md_result),
      .o_overflow (w_md_overflow)
   );

   // Single-cycle datapath evaluated on the captured operands
   always_comb begin
      w_res  = W_ZERO;
      w_c    = 1'b0;
      w_v    = 1'b0;
      w_d    = 1'b0;
      w_wide = {1'b0, W_ZERO};
      w_pa   = r_sgn ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {W_ZERO, r_a};
      w_pb   = r_sgn ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {W_ZERO, r_b};
      w_prod = w_pa * w_pb;
      case (r_op)
         ALU_OP_ADD: begin
            w_wide = {1'b0, r_a} + {1'b0, r_b};
            w_res  = w_wide[WIDTH-1:0];
            w_c    = w_wide[WIDTH];
            w_v    = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
         end
         ALU_OP_SUB: begin
            w_wide = {1'b0, r_a} - {1'b0, r_b};
            w_res  = w_wide[WIDTH-1:0];
            w_c    = w_wide[WIDTH];
            w_v    = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
         end
         ALU_OP_MUL: begin
            // Only reached with FAST_MUL=1
            w_res = w_prod[WIDTH-1:0];
            if (r_sgn) begin
               w_v = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});
            end else begin
               w_v = (w_prod[2*WIDTH-1:WIDTH] != W_ZERO);
            end
         end
         ALU_OP_DIV: begin
            if (r_b == W_ZERO) begin
               w_d = 1'b1;
            end else begin
               w_res = W_MAX;
               w_v   = 1'b1;
            end
         end
         ALU_OP_SHL: begin
            w_res = {r_a[WIDTH-2:0], 1'b0};
            w_c   = r_a[WIDTH-1];
         end
         ALU_OP_SHR: begin
            w_res = {r_sgn & r_a[WIDTH-1], r_a[WIDTH-1:1]};
            w_c   = r_a[0];
         end
         ALU_OP_ROL: begin
            w_res = {r_a[WIDTH-2:0], r_a[WIDTH-1]};
            w_c   = r_a[WIDTH-1];
         end
         ALU_OP_ROR: begin
            w_res = {r_a[0], r_a[WIDTH-1:1]};
            w_c   = r_a[0];
         end
         ALU_OP_AND:  w_res = r_a & r_b;
         ALU_OP_OR:   w_res = r_a | r_b;
         ALU_OP_XOR:  w_res = r_a ^ r_b;
         ALU_OP_NOR:  w_res = ~(r_a | r_b);
         ALU_OP_NAND: w_res = ~(r_a & r_b);
         ALU_OP_XNOR: w_res = ~(r_a ^ r_b);
         ALU_OP_GT: begin
            if (r_sgn) begin
               w_res = {{(WIDTH-1){1'b0}}, ($signed(r_a) > $signed(r_b))};
            end else begin
               w_res = {{(WIDTH-1){1'b0}}, (r_a > r_b)};
            end
         end
         ALU_OP_EQ:   w_res = {{(WIDTH-1){1'b0}}, (r_a == r_b)};
         default:     w_res = W_ZERO;
      endcase
   end

   // Flag vectors for both completion paths
   always_comb begin
      w_flags_exec         = {FLAG_W{1'b0}};
      w_flags_exec[FLAG_C] = w_c;
      w_flags_exec[FLAG_V] = w_v;
      w_flags_exec[FLAG_Z] = (w_res == W_ZERO);
      w_flags_exec[FLAG_N] = w_res[WIDTH-1];
      w_flags_exec[FLAG_D] = w_d;

      w_flags_md           = {FLAG_W{1'b0}};
      w_flags_md[FLAG_V]   = w_md_overflow;
      w_flags_md[FLAG_Z]   = (w_md_result == W_ZERO);
      w_flags_md[FLAG_N]   = w_md_result[WIDTH-1];
   end

   // Controller FSM; result and flags only change on entry to DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_a      <= W_ZERO;
         r_b      <= W_ZERO;
         r_op     <= ALU_OP_ADD;
         r_sgn    <= 1'b0;
         r_result <= W_ZERO;
         r_flags  <= {FLAG_W{1'b0}};
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_a     <= op_a;
                  r_b     <= op_b;
                  r_op    <= opcode;
                  r_sgn   <= signed_mode;
                  r_state <= w_iter ? ST_BUSY : ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_result <= w_res;
               r_flags  <= w_flags_exec;
               r_state  <= ST_DONE;
            end
            ST_BUSY: begin
               if (w_md_done) begin
                  r_result <= w_md_result;
                  r_flags  <= w_flags_md;
                  r_state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Output mapping from registered state
   always_comb begin
      out_valid     = (r_state == ST_DONE);
      result        = r_result;
      carry_flag    = r_flags[FLAG_C];
      overflow_flag = r_flags[FLAG_V];
      zero_flag     = r_flags[FLAG_Z];
      negative_flag = r_flags[FLAG_N];
      div0_flag     = r_flags[FLAG_D];
   end

endmodule

// File: tb/tb_alu_seq_core.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_core
// Directed and random operations on alu_seq_core (WIDTH=8, FAST_MUL=0),
// checked against an integer-arithmetic reference model. Latency is counted
// with the accept cycle as cycle 0: out_valid is expected in cycle 2 for
// single-cycle ops and in cycle WIDTH+1 for iterative MUL/DIV.
// ---------------------------------------------------------------------------
module tb_alu_seq_core;

   localparam int W = 8;
   localparam int M = 1 << W;
   localparam int H = 1 << (W - 1);

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic [3:0]   opcode;
   logic         signed_mode;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         carry_flag, zero_flag, overflow_flag, negative_flag, div0_flag;
   logic [4:0]   dut_flags;

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] obs_res;
   logic [4:0]   obs_flags;

   always #5 clk = ~clk;

   alu_seq_core #(.WIDTH(W), .FAST_MUL(0)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .op_a          (op_a),
      .op_b          (op_b),
      .opcode        (opcode),
      .signed_mode   (signed_mode),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .result        (result),
      .carry_flag    (carry_flag),
      .zero_flag     (zero_flag),
      .overflow_flag (overflow_flag),
      .negative_flag (negative_flag),
      .div0_flag     (div0_flag)
   );

   // {div0, N, Z, V, C}
   assign dut_flags = {div0_flag, negative_flag, zero_flag, overflow_flag, carry_flag};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on the operand values
   function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sgn, output logic [W-1:0] r, output logic [4:0] f,
                                 output int lat);
      int  ua, ub, sa, sb, t;
      logic c, v, d;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      t = 0; c = 1'b0; v = 1'b0; d = 1'b0; lat = 2; r = '0;
      case (op)
         4'h0: begin t = ua + ub; r = t[W-1:0]; c = (t >= M); v = (sa + sb >= H) || (sa + sb < -H); end
         4'h1: begin t = ua - ub; r = t[W-1:0]; c = (ua < ub); v = (sa - sb >= H) || (sa - sb < -H); end
         4'h2: begin
            lat = W + 1;
            if (sgn) begin t = sa * sb; v = (t >= H) || (t < -H); end
            else begin t = ua * ub; v = (t >= M); end
            r = t[W-1:0];
         end
         4'h3: begin
            if (ub == 0) begin r = '0; d = 1'b1; end
            else if (sgn && sa == -H && sb == -1) begin t = H - 1; r = t[W-1:0]; v = 1'b1; end
            else begin lat = W + 1; t = sgn ? sa / sb : ua / ub; r = t[W-1:0]; end
         end
         4'h4: begin t = ua * 2; r = t[W-1:0]; c = (ua >= H); end
         4'h5: begin t = sgn ? (sa >>> 1) : (ua >> 1); r = t[W-1:0]; c = (ua % 2 == 1); end
         4'h6: begin t = (ua * 2) % M + ua / H; r = t[W-1:0]; c = (ua >= H); end
         4'h7: begin t = ua / 2 + (ua % 2) * H; r = t[W-1:0]; c = (ua % 2 == 1); end
         4'h8: r = a & b;
         4'h9: r = a | b;
         4'hA: r = a ^ b;
         4'hB: r = ~(a | b);
         4'hC: r = ~(a & b);
         4'hD: r = ~(a ^ b);
         4'hE: begin t = (sgn ? (sa > sb) : (ua > ub)) ? 1 : 0; r = t[W-1:0]; end
         default: begin t = (ua == ub) ? 1 : 0; r = t[W-1:0]; end
      endcase
      f = {d, r[W-1], (r == '0), v, c};
   endfunction

   // Issue one op, check latency/result/flags, optionally stall the output
   task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sgn, input int stall);
      logic [W-1:0] er;
      logic [4:0]   ef;
      int           elat;
      int           cyc;
      model(op, a, b, sgn, er, ef, elat);
      @(negedge clk);
      chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
      opcode = op; op_a = a; op_b = b; signed_mode = sgn; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      op_a = W'($urandom); op_b = W'($urandom); opcode = 4'($urandom); signed_mode = 1'($urandom);
      cyc = 1;
      while (out_valid !== 1'b1 && cyc < 4 * W) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("latency", 32'(cyc), 32'(elat));
      chk("result", {24'd0, result}, {24'd0, er});
      chk("flags", {27'd0, dut_flags}, {27'd0, ef});
      obs_res = result;
      obs_flags = dut_flags;
      // New requests while the result is held must be ignored
      in_valid = 1'b1;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         chk("hold_result", {24'd0, result}, {24'd0, er});
         chk("hold_flags", {27'd0, dut_flags}, {27'd0, ef});
         chk("hold_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
         op_a = W'($urandom); op_b = W'($urandom); opcode = 4'($urandom);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("valid_drop", {31'd0, out_valid}, 32'd0);
      chk("ready_back", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] ra, rb;
      logic [3:0]   rop;
      bit           seen;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      op_a = '0; op_b = '0; opcode = 4'h0; signed_mode = 1'b0;
      #1;
      chk("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_result", {24'd0, result}, 32'd0);
      chk("rst_flags", {27'd0, dut_flags}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Directed cases with literal expectations ({div0,N,Z,V,C})
      run_op(4'h0, 8'h7F, 8'h01, 1'b0, 0);
      chk("add_res", {24'd0, obs_res}, 32'h80);
      chk("add_flags", {27'd0, obs_flags}, 32'b01010);
      run_op(4'h1, 8'h00, 8'h01, 1'b0, 0);
      chk("sub_res", {24'd0, obs_res}, 32'hFF);
      chk("sub_flags", {27'd0, obs_flags}, 32'b01001);
      run_op(4'hF, 8'h5A, 8'h5A, 1'b0, 0);
      chk("eq_res", {24'd0, obs_res}, 32'h01);
      chk("eq_flags", {27'd0, obs_flags}, 32'b00000);
      run_op(4'h2, 8'hFD, 8'h07, 1'b1, 0);
      chk("smul_res", {24'd0, obs_res}, 32'hEB);
      chk("smul_flags", {27'd0, obs_flags}, 32'b01000);
      run_op(4'h2, 8'h20, 8'h10, 1'b0, 0);
      chk("umul_res", {24'd0, obs_res}, 32'h00);
      chk("umul_flags", {27'd0, obs_flags}, 32'b00110);
      run_op(4'h3, 8'hF9, 8'h02, 1'b1, 0);
      chk("sdiv_res", {24'd0, obs_res}, 32'hFD);
      run_op(4'h3, 8'h80, 8'hFF, 1'b1, 0);
      chk("div_minm1_res", {24'd0, obs_res}, 32'h7F);
      chk("div_minm1_flags", {27'd0, obs_flags}, 32'b00010);
      run_op(4'h3, 8'h37, 8'h00, 1'b0, 0);
      chk("div0_res", {24'd0, obs_res}, 32'h00);
      chk("div0_flags", {27'd0, obs_flags}, 32'b10100);
      run_op(4'h5, 8'h81, 8'h00, 1'b1, 0);
      chk("sar_res", {24'd0, obs_res}, 32'hC0);
      run_op(4'hA, 8'hC3, 8'h5A, 1'b0, 5);
      chk("bp_res", {24'd0, obs_res}, 32'h99);

      // Reset during cycle 4 of an iterative DIV
      @(negedge clk);
      opcode = 4'h3; op_a = 8'hC8; op_b = 8'h07; signed_mode = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_result", {24'd0, result}, 32'd0);
      chk("abort_flags", {27'd0, dut_flags}, 32'd0);
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
      rst = 1'b0;
      #1;
      chk("abort_ready_back", {31'd0, in_ready}, 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 2 * W; i++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) seen = 1'b1;
      end
      chk("abort_no_valid", {31'd0, seen}, 32'd0);
      run_op(4'h3, 8'hC8, 8'h07, 1'b0, 0);
      chk("after_abort_res", {24'd0, obs_res}, 32'h1C);

      // Random operations against the model
      for (int n = 0; n < 80; n++) begin
         rop = 4'($urandom_range(0, 15));
         ra = W'($urandom);
         case ($urandom_range(0, 7))
            0: rb = 8'h00;
            1: rb = 8'hFF;
            2: begin ra = 8'h80; rb = 8'hFF; end
            default: rb = W'($urandom);
         endcase
         run_op(rop, ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
